instr_fetch: RTL
================

# instr_fetch

Instruction fetch unit that feeds the main control decoder and the rest of the single-issue MIPS datapath. Holds the PC and issues sequential word reads to a synchronous instruction memory with 1-cycle read latency. Buffers returned words with their PCs in a small FIFO and presents them to decode over a valid/ready handshake. Supports branch/jump redirect with flush of buffered and in-flight fetches.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC fetched first after reset; bits [1:0] ignored (forced 00)
- DEPTH, 4, fetch buffer entries; power of two, 2..16

Ports:
- clk  input  1  single clock, all state on rising edge
- reset  input  1  synchronous, active-high
- imem_req  output  1  read request this cycle
- imem_addr  output  32  word-aligned read address, valid when imem_req=1
- imem_rdata  input  32  read data; valid exactly 1 cycle after the accepted imem_req
- redirect  input  1  branch/jump taken; 1-cycle pulse
- redirect_pc  input  32  new PC; bits [1:0] forced to 00
- instr_valid  output  1  FIFO head holds a valid instruction
- instr_ready  input  1  decode accepts head this cycle
- instr  output  32  head instruction word
- opcode  output  6  instr[31:26], drives the control decoder directly
- instr_pc  output  32  PC of head instruction
- instr_pc4  output  32  instr_pc + 4, modulo 2^32

## Operation
- State: pc (32), inflight flag (1 bit), inflight_pc (32), FIFO of DEPTH entries of {instr, pc}, count (log2(DEPTH)+1 bits).
- Pop: instr_valid && instr_ready removes head.
- Issue condition: !reset && !redirect && (count + inflight − pop) < DEPTH. When issuing: imem_req=1, imem_addr=pc, pc <= pc+4 (wraps 32'hFFFF_FFFC -> 0), inflight <= 1, inflight_pc <= pc; otherwise inflight <= 0.
- Response: if inflight was set last cycle and not squashed, push {imem_rdata, inflight_pc} at this edge. Push and pop may occur in the same cycle; count unchanged.
- Credit rule guarantees push never finds FIFO full; no overflow path exists.
- Redirect (highest priority after reset): at that edge FIFO emptied (count=0, pointers reset), any in-flight response arriving this cycle or next is discarded, pc <= {redirect_pc[31:2],2'b00}, no request issued in the redirect cycle. A pop in the redirect cycle is still honoured by decode but the FIFO is flushed regardless.
- Redirect on consecutive cycles: last one wins.
- instr/opcode/instr_pc/instr_pc4 driven from FIFO head; when instr_valid=0 they are 0.
- Reset (any cycle, including mid-fetch): pc=RESET_PC aligned, FIFO empty, inflight=0, pending response dropped.

## Timing
- Reset values: imem_req=0, imem_addr=0, instr_valid=0, instr=0, opcode=0, instr_pc=0, instr_pc4=0.
- Cycle R = first cycle reset low: imem_req=1, imem_addr=RESET_PC.
- Cycle R+1: imem_rdata for RESET_PC sampled, pushed at end of R+1.
- Cycle R+2: instr_valid=1, instr_pc=RESET_PC. Fetch-to-decode latency 2 cycles.
- Redirect at cycle T: imem_req=0 in T; T+1 imem_req=1, imem_addr=redirect_pc; T+3 instr_valid=1 with instr_pc=redirect_pc. instr_valid=0 in T+1, T+2.
- Steady state, instr_ready held 1: one instruction per cycle, no bubbles, for DEPTH≥2.
- instr_ready=0: at most DEPTH words buffered; imem_req drops once count+inflight=DEPTH; restarts the cycle after a pop frees credit, with no lost or duplicated PC.
- instr_valid and head outputs stable while instr_ready=0 (no change without pop).

## Test plan
- Reset release, memory word[i]=i, ready=1 -> imem_addr 0,4,8,... one per cycle from R; instr_valid from R+2; instr sequence 0,1,2,... with instr_pc 0,4,8.
- Hold instr_ready=0 for 10 cycles after reset (DEPTH=4) -> exactly 4 requests (0,4,8,12), imem_req=0 afterwards; release ready -> instr_pc 0,4,8,12,16 in order, none missing or repeated.
- Redirect to 32'h0000_0103 while 3 entries buffered and one in flight -> FIFO cleared, next issue addr 32'h0000_0100, first valid instr_pc=0x100 at T+3, no stale word delivered.
- Redirect asserted two consecutive cycles (0x40 then 0x80) -> only 0x80 stream delivered.
- RESET_PC=32'hFFFF_FFF8, ready=1 -> instr_pc FFFF_FFF8, FFFF_FFFC, 0000_0000; instr_pc4 of FFFF_FFFC is 0.
- Assert reset for one cycle mid-stream with one fetch in flight -> all outputs 0 next cycle, restart from RESET_PC, in-flight word never appears.

Source files
------------

// File: rtl/instr_fetch_if.sv
// Fetch-unit bus bundle: instruction-memory read port, redirect input and
// the decode-side valid/ready instruction stream.
interface instr_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc4;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, opcode, instr_pc, instr_pc4,
    input  imem_rdata, redirect, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, opcode, instr_pc, instr_pc4,
    output imem_rdata, redirect, redirect_pc, instr_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: sequential PC, 1-cycle-latency memory reads buffered
// with their PCs in a DEPTH-entry FIFO, branch/jump redirect with full flush.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic          clk,
  input  logic          reset,
  instr_fetch_if.master bus
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [31:0] RESET_PC_AL = {RESET_PC[31:2], 2'b00};
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [31:0]   pc_q, pc_d;
  logic          inflight_q, inflight_d;
  logic [31:0]   inflight_pc_q, inflight_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   mem_instr_q [DEPTH];
  logic [31:0]   mem_pc_q    [DEPTH];

  logic          valid_s;
  logic          pop_s;
  logic          push_s;
  logic          issue_s;
  logic [CW:0]   occ_s;
  logic [31:0]   head_instr_s;
  logic [31:0]   head_pc_s;
  logic [31:0]   head_pc4_s;
  logic          unused_bits_s;

  assign unused_bits_s = ^bus.redirect_pc[1:0];

  // Credit check counts the in-flight read so a returning word always finds room.
  assign valid_s = (count_q != '0);
  assign pop_s   = valid_s && bus.instr_ready;
  assign push_s  = inflight_q && !bus.redirect;
  assign occ_s   = (CW+1)'(count_q) + (CW+1)'(inflight_q) - (CW+1)'(pop_s);
  assign issue_s = !reset && !bus.redirect && (occ_s < DEPTH_W);

  // Next-state logic; a redirect flushes everything and drops the arriving word.
  always_comb begin
    pc_d          = pc_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    if (bus.redirect) begin
      pc_d       = {bus.redirect_pc[31:2], 2'b00};
      inflight_d = 1'b0;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      inflight_d = issue_s;
      if (issue_s) begin
        pc_d          = pc_q + 32'd4;
        inflight_pc_d = pc_q;
      end else begin
        pc_d          = pc_q;
        inflight_pc_d = inflight_pc_q;
      end
      if (push_s) wr_ptr_d = wr_ptr_q + PW'(1);
      else        wr_ptr_d = wr_ptr_q;
      if (pop_s)  rd_ptr_d = rd_ptr_q + PW'(1);
      else        rd_ptr_d = rd_ptr_q;
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC_AL;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'h0000_0000;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
    end
  end

  // FIFO storage; contents are only observed through valid entries.
  always_ff @(posedge clk) begin
    if (!reset && push_s) begin
      mem_instr_q[wr_ptr_q] <= bus.imem_rdata;
      mem_pc_q[wr_ptr_q]    <= inflight_pc_q;
    end
  end

  // Head presentation, zeroed while the buffer is empty.
  always_comb begin
    head_instr_s = 32'h0000_0000;
    head_pc_s    = 32'h0000_0000;
    head_pc4_s   = 32'h0000_0000;
    if (valid_s) begin
      head_instr_s = mem_instr_q[rd_ptr_q];
      head_pc_s    = mem_pc_q[rd_ptr_q];
      head_pc4_s   = mem_pc_q[rd_ptr_q] + 32'd4;
    end else begin
      head_instr_s = 32'h0000_0000;
      head_pc_s    = 32'h0000_0000;
      head_pc4_s   = 32'h0000_0000;
    end
  end

  assign bus.imem_req    = issue_s;
  assign bus.imem_addr   = issue_s ? pc_q : 32'h0000_0000;
  assign bus.instr_valid = valid_s;
  assign bus.instr       = head_instr_s;
  assign bus.opcode      = head_instr_s[31:26];
  assign bus.instr_pc    = head_pc_s;
  assign bus.instr_pc4   = head_pc4_s;

endmodule
